// File: rtl/prot_stim_gen.sv
// prot_stim_gen
// Runtime-configurable protocol stimulus generator. It produces bursts of UART
// frames (8N1, LSB first) or SPI frames (CPOL=1, MSB first, selectable drive
// edge, 8- or SPI_W-bit). It is used to exercise the analyzer's protocol
// triggers. Configuration is captured when a burst starts, and every output
// comes straight from a flop.
module prot_stim_gen #(
   parameter int SPI_W    = 16,
   parameter int BAUD_W   = 16,
   parameter int SCLK_DIV = 32,
   parameter int RPT_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              strt,
   input  logic [1:0]        mode,
   input  logic [SPI_W-1:0]  data,
   input  logic [BAUD_W-1:0] baud_cnt,
   input  logic              spi_w8,
   input  logic              spi_pos_edge,
   input  logic [RPT_W-1:0]  rpt_cnt,
   output logic              busy,
   output logic              done,
   output logic [RPT_W:0]    frm_cnt,
   output logic              tx,
   output logic              SS_n,
   output logic              SCLK,
   output logic              MOSI
);

   localparam int SCLK_W = $clog2(SCLK_DIV);
   localparam int IDX_W  = $clog2(SPI_W);

   localparam logic [SCLK_W-1:0] HALF_END  = SCLK_W'(SCLK_DIV / 2 - 1);
   localparam logic [SCLK_W-1:0] GAP_END   = SCLK_W'(SCLK_DIV - 1);
   localparam logic [IDX_W-1:0]  UART_LAST = IDX_W'(7);
   localparam logic [IDX_W-1:0]  SPI8_LAST = IDX_W'(7);
   localparam logic [IDX_W-1:0]  SPIW_LAST = IDX_W'(SPI_W - 1);
   localparam logic [RPT_W:0]    FRM_MAX   = {1'b1, {RPT_W{1'b0}}};
   localparam logic [1:0]        MODE_UART = 2'b01;
   localparam logic [1:0]        MODE_SPI  = 2'b10;

   typedef enum logic [3:0] {
      IDLE,
      U_START,
      U_DATA,
      U_STOP,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP,
      FIN
   } state_t;

   state_t state, state_nxt;

   // Configuration captured at burst start
   logic [SPI_W-1:0]  data_l;
   logic [BAUD_W-1:0] baud_l;
   logic              w8_l;
   logic              pos_l;
   logic [RPT_W-1:0]  rpt_l;

   // Datapath state and its next values
   logic [BAUD_W-1:0] baud_tmr, baud_tmr_nxt;
   logic [SCLK_W-1:0] sclk_tmr, sclk_tmr_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [SPI_W-1:0]  sr, sr_nxt;
   logic [RPT_W:0]    frm_cnt_nxt;
   logic              busy_nxt, done_nxt, tx_nxt, ss_n_nxt, sclk_nxt, mosi_nxt;

   // Decoded conditions
   logic              start;
   logic              baud_end;
   logic              half_end;
   logic              last_frm;
   logic [IDX_W-1:0]  spi_last;
   logic [RPT_W:0]    frm_inc;
   logic [BAUD_W-1:0] baud_clamp;

   // A start is honoured in IDLE and in the single FIN cycle, for a valid mode.
   assign start = ((state == IDLE) || (state == FIN)) && strt &&
                  ((mode == MODE_UART) || (mode == MODE_SPI));

   // A bit period below two cycles is raised to two.
   assign baud_clamp = (baud_cnt < BAUD_W'(2)) ? BAUD_W'(2) : baud_cnt;

   assign baud_end = (baud_tmr == baud_l - BAUD_W'(1));
   assign half_end = (sclk_tmr == HALF_END);
   assign spi_last = w8_l ? SPI8_LAST : SPIW_LAST;
   assign last_frm = (frm_cnt == {1'b0, rpt_l});
   assign frm_inc  = (frm_cnt == FRM_MAX) ? frm_cnt : frm_cnt + (RPT_W+1)'(1);

   // Capture the burst configuration so later input changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_l <= '0;
         baud_l <= BAUD_W'(2);
         w8_l   <= 1'b0;
         pos_l  <= 1'b0;
         rpt_l  <= '0;
      end else if (start) begin
         // NOTE: clocked state always uses non-blocking assignments so every
         // flop samples the pre-edge values regardless of statement order.
         data_l <= data;
         baud_l <= baud_clamp;
         w8_l   <= spi_w8;
         pos_l  <= spi_pos_edge;
         rpt_l  <= rpt_cnt;
      end
   end

   // State register, timers and registered outputs; reset drives idle levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_tmr <= '0;
         sclk_tmr <= '0;
         idx      <= '0;
         sr       <= '0;
         frm_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx       <= 1'b1;
         SS_n     <= 1'b1;
         SCLK     <= 1'b1;
         MOSI     <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_tmr <= baud_tmr_nxt;
         sclk_tmr <= sclk_tmr_nxt;
         idx      <= idx_nxt;
         sr       <= sr_nxt;
         frm_cnt  <= frm_cnt_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         tx       <= tx_nxt;
         SS_n     <= ss_n_nxt;
         SCLK     <= sclk_nxt;
         MOSI     <= mosi_nxt;
      end
   end

   // Next state, next timer values and next output levels.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nxt    = state;
      baud_tmr_nxt = baud_tmr;
      sclk_tmr_nxt = sclk_tmr;
      idx_nxt      = idx;
      sr_nxt       = sr;
      frm_cnt_nxt  = frm_cnt;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      tx_nxt       = tx;
      ss_n_nxt     = SS_n;
      sclk_nxt     = SCLK;
      mosi_nxt     = MOSI;

      case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            if (start) begin
               frm_cnt_nxt = '0;
               busy_nxt    = 1'b1;
               sr_nxt      = data;
               if (mode == MODE_UART) begin
                  state_nxt    = U_START;
                  baud_tmr_nxt = '0;
                  tx_nxt       = 1'b0;
               end else begin
                  state_nxt    = S_SETUP;
                  sclk_tmr_nxt = '0;
                  ss_n_nxt     = 1'b0;
                  sclk_nxt     = 1'b1;
                  mosi_nxt     = data[SPI_W-1];
               end
            end
         end

         U_START: begin
            if (baud_end) begin
               state_nxt    = U_DATA;
               baud_tmr_nxt = '0;
               idx_nxt      = '0;
               tx_nxt       = sr[0];
            end else begin
               baud_tmr_nxt = baud_tmr + BAUD_W'(1);
            end
         end

         U_DATA: begin
            if (baud_end) begin
               baud_tmr_nxt = '0;
               if (idx == UART_LAST) begin
                  state_nxt = U_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
                  sr_nxt  = sr >> 1;
                  tx_nxt  = sr[1];
               end
            end else begin
               baud_tmr_nxt = baud_tmr + BAUD_W'(1);
            end
         end

         U_STOP: begin
            if (baud_end) begin
               baud_tmr_nxt = '0;
               frm_cnt_nxt  = frm_inc;
               if (last_frm) begin
                  state_nxt = FIN;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  // Next start bit follows the stop bit with no idle gap.
                  state_nxt = U_START;
                  tx_nxt    = 1'b0;
                  sr_nxt    = data_l;
               end
            end else begin
               baud_tmr_nxt = baud_tmr + BAUD_W'(1);
            end
         end

         S_SETUP: begin
            if (half_end) begin
               state_nxt    = S_SHIFT;
               sclk_tmr_nxt = '0;
               idx_nxt      = '0;
               sclk_nxt     = 1'b0;
            end else begin
               sclk_tmr_nxt = sclk_tmr + SCLK_W'(1);
            end
         end

         S_SHIFT: begin
            if (half_end) begin
               sclk_tmr_nxt = '0;
               if (!SCLK) begin
                  // Rising edge of pulse idx; rise-driven mode advances here
                  // except on the final pulse.
                  sclk_nxt = 1'b1;
                  if (pos_l && (idx != spi_last)) begin
                     sr_nxt   = sr << 1;
                     mosi_nxt = sr[SPI_W-2];
                  end
               end else if (idx == spi_last) begin
                  state_nxt = S_HOLD;
               end else begin
                  // Falling edge starting the next pulse; fall-driven mode
                  // advances here (the very first fall came from S_SETUP).
                  sclk_nxt = 1'b0;
                  idx_nxt  = idx + IDX_W'(1);
                  if (!pos_l) begin
                     sr_nxt   = sr << 1;
                     mosi_nxt = sr[SPI_W-2];
                  end
               end
            end else begin
               sclk_tmr_nxt = sclk_tmr + SCLK_W'(1);
            end
         end

         S_HOLD: begin
            if (half_end) begin
               sclk_tmr_nxt = '0;
               ss_n_nxt     = 1'b1;
               mosi_nxt     = 1'b0;
               frm_cnt_nxt  = frm_inc;
               if (last_frm) begin
                  state_nxt = FIN;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_GAP;
               end
            end else begin
               sclk_tmr_nxt = sclk_tmr + SCLK_W'(1);
            end
         end

         S_GAP: begin
            if (sclk_tmr == GAP_END) begin
               state_nxt    = S_SETUP;
               sclk_tmr_nxt = '0;
               ss_n_nxt     = 1'b0;
               sr_nxt       = data_l;
               mosi_nxt     = data_l[SPI_W-1];
            end else begin
               sclk_tmr_nxt = sclk_tmr + SCLK_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_prot_stim_gen.sv
// tb_prot_stim_gen
// Directed bursts with hand-computed expectations pushed into scoreboards.
// Independent UART, SPI and burst monitors decode the pins and compare.
module tb_prot_stim_gen;

   logic        clk;
   logic        rst;
   logic        strt;
   logic [1:0]  mode;
   logic [15:0] data;
   logic [15:0] baud_cnt;
   logic        spi_w8;
   logic        spi_pos_edge;
   logic [3:0]  rpt_cnt;
   logic        busy;
   logic        done;
   logic [4:0]  frm_cnt;
   logic        tx;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] ub;
      int         baud;
   } uart_exp_t;

   typedef struct {
      logic [15:0] word;
      int          nbits;
      logic        pos;
      int          low_len;
      int          gap;
   } spi_exp_t;

   typedef struct {
      logic [4:0] frames;
      int         busy_len;
   } burst_exp_t;

   uart_exp_t  uart_q[$];
   spi_exp_t   spi_q[$];
   burst_exp_t burst_q[$];

   prot_stim_gen #(
      .SPI_W(16), .BAUD_W(16), .SCLK_DIV(32), .RPT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .strt(strt), .mode(mode), .data(data),
      .baud_cnt(baud_cnt), .spi_w8(spi_w8), .spi_pos_edge(spi_pos_edge),
      .rpt_cnt(rpt_cnt), .busy(busy), .done(done), .frm_cnt(frm_cnt),
      .tx(tx), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_uart(input logic [7:0] ub, input int baud, input int n);
      uart_exp_t e;
      e.ub   = ub;
      e.baud = baud;
      for (int i = 0; i < n; i++) uart_q.push_back(e);
   endtask

   task automatic exp_spi(input logic [15:0] word, input int nbits, input logic pos,
                          input int low_len, input int gap);
      spi_exp_t e;
      e.word    = word;
      e.nbits   = nbits;
      e.pos     = pos;
      e.low_len = low_len;
      e.gap     = gap;
      spi_q.push_back(e);
   endtask

   task automatic exp_burst(input logic [4:0] frames, input int busy_len);
      burst_exp_t e;
      e.frames   = frames;
      e.busy_len = busy_len;
      burst_q.push_back(e);
   endtask

   // ---------------- UART monitor ----------------
   uart_exp_t  um_e;
   logic       um_act  = 1'b0;
   logic       um_prev = 1'b1;
   logic [9:0] um_pat;
   int         um_bit, um_cyc, um_bad;

   always @(negedge clk) begin
      if (rst) begin
         um_act = 1'b0;
      end else begin
         if (!um_act && tx === 1'b0 && um_prev === 1'b1) begin
            check("uart_frame_expected", uart_q.size() > 0, 1);
            if (uart_q.size() > 0) begin
               um_e   = uart_q.pop_front();
               um_pat = {1'b1, um_e.ub, 1'b0};
               um_act = 1'b1;
               um_bit = 0;
               um_cyc = 0;
               um_bad = 0;
            end
         end
         if (um_act) begin
            if (tx !== um_pat[um_bit]) um_bad++;
            um_cyc++;
            if (um_cyc == um_e.baud) begin
               check($sformatf("uart_bit%0d_bad_cycles", um_bit), um_bad, 0);
               um_bad = 0;
               um_cyc = 0;
               um_bit++;
               if (um_bit == 10) um_act = 1'b0;
            end
         end
      end
      um_prev = tx;
   end

   // ---------------- SPI monitor ----------------
   spi_exp_t    sm_e;
   logic        sm_act       = 1'b0;
   logic        sm_prev_ss   = 1'b1;
   logic        sm_prev_sclk = 1'b1;
   logic        sm_prev_mosi = 1'b0;
   logic [15:0] sm_word;
   int          sm_low, sm_high, sm_pulses, sm_unstable;
   logic        sm_edge;

   always @(negedge clk) begin
      if (rst) begin
         sm_act  = 1'b0;
         sm_high = 0;
      end else begin
         if (!sm_act && SS_n === 1'b0 && sm_prev_ss === 1'b1) begin
            check("spi_frame_expected", spi_q.size() > 0, 1);
            if (spi_q.size() > 0) begin
               sm_e = spi_q.pop_front();
               if (sm_e.gap > 0) check("spi_gap_len", sm_high, sm_e.gap);
               sm_act      = 1'b1;
               sm_low      = 0;
               sm_pulses   = 0;
               sm_unstable = 0;
               sm_word     = '0;
            end
         end
         if (sm_act) begin
            if (SS_n === 1'b0) begin
               sm_low++;
               if (sm_prev_sclk === 1'b0 && SCLK === 1'b1) sm_pulses++;
               sm_edge = sm_e.pos ? (sm_prev_sclk === 1'b1 && SCLK === 1'b0)
                                  : (sm_prev_sclk === 1'b0 && SCLK === 1'b1);
               if (sm_edge) begin
                  sm_word = {sm_word[14:0], MOSI};
                  if (MOSI !== sm_prev_mosi) sm_unstable++;
               end
            end else begin
               check("spi_word", sm_word, sm_e.word);
               check("spi_pulses", sm_pulses, sm_e.nbits);
               check("spi_ss_low_len", sm_low, sm_e.low_len);
               check("spi_mosi_unstable", sm_unstable, 0);
               check("spi_mosi_after_ss", MOSI, 0);
               check("spi_sclk_after_ss", SCLK, 1);
               sm_act  = 1'b0;
               sm_high = 0;
            end
         end
         if (!sm_act && SS_n === 1'b1) sm_high++;
      end
      sm_prev_ss   = SS_n;
      sm_prev_sclk = SCLK;
      sm_prev_mosi = MOSI;
   end

   // ---------------- burst monitor ----------------
   burst_exp_t bm_e;
   int         bm_len = 0;

   always @(negedge clk) begin
      if (rst) begin
         bm_len = 0;
      end else begin
         if (busy === 1'b1) bm_len++;
         if (done === 1'b1) begin
            check("done_expected", burst_q.size() > 0, 1);
            if (burst_q.size() > 0) begin
               bm_e = burst_q.pop_front();
               check("frm_cnt_at_done", frm_cnt, bm_e.frames);
               check("busy_len", bm_len, bm_e.busy_len);
               check("busy_at_done", busy, 0);
            end
            bm_len = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_burst(input logic [1:0] m, input logic [15:0] d, input logic [15:0] b,
                              input logic w8, input logic pe, input logic [3:0] r);
      mode         = m;
      data         = d;
      baud_cnt     = b;
      spi_w8       = w8;
      spi_pos_edge = pe;
      rpt_cnt      = r;
      strt         = 1'b1;
      tick();
      strt         = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      check("wait_done", done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      strt         = 1'b0;
      mode         = 2'b00;
      data         = '0;
      baud_cnt     = '0;
      spi_w8       = 1'b0;
      spi_pos_edge = 1'b0;
      rpt_cnt      = '0;
      tick(3);
      check("rst_tx", tx, 1);
      check("rst_ss_n", SS_n, 1);
      check("rst_sclk", SCLK, 1);
      check("rst_mosi", MOSI, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frm_cnt", frm_cnt, 0);
      rst = 1'b0;
      tick(2);

      // UART 0x96 at 8 cycles/bit: 80-cycle busy window, one frame.
      exp_uart(8'h96, 8, 1);
      exp_burst(5'd1, 80);
      start_burst(2'b01, 16'h0096, 16'd8, 1'b0, 1'b0, 4'd0);
      check("u1_busy_rise", busy, 1);
      check("u1_tx_start", tx, 0);
      wait_done(200);
      tick();
      check("u1_done_one_cycle", done, 0);
      check("u1_busy_after", busy, 0);
      tick(2);

      // UART 0xA5, baud 1 clamped to 2, three back-to-back frames; inputs
      // scrambled after the start must not matter.
      exp_uart(8'hA5, 2, 3);
      exp_burst(5'd3, 60);
      start_burst(2'b01, 16'h00A5, 16'd1, 1'b0, 1'b0, 4'd2);
      check("u2_frm_clear", frm_cnt, 0);
      data     = 16'hFFFF;
      baud_cnt = 16'd9;
      rpt_cnt  = 4'd0;
      mode     = 2'b10;
      wait_done(200);
      tick(2);

      // Maximum repeat count: 16 frames, frm_cnt reaches 2^RPT_W.
      exp_uart(8'h81, 2, 16);
      exp_burst(5'h10, 320);
      start_burst(2'b01, 16'h0081, 16'd2, 1'b0, 1'b0, 4'hF);
      wait_done(600);
      tick(2);

      // Start while busy is ignored.
      exp_uart(8'h3C, 4, 2);
      exp_burst(5'd2, 80);
      start_burst(2'b01, 16'h003C, 16'd4, 1'b0, 1'b0, 4'd1);
      check("u3_frm_clear", frm_cnt, 0);
      tick(15);
      data = 16'h00F0;
      strt = 1'b1;
      tick();
      strt = 1'b0;
      check("u3_busy_kept", busy, 1);
      wait_done(200);

      // Start presented in the done cycle is accepted straight away.
      exp_spi(16'h005A, 8, 1'b1, 288, 0);
      exp_burst(5'd1, 288);
      start_burst(2'b10, 16'h5A00, 16'd0, 1'b1, 1'b1, 4'd0);
      check("s0_busy_after_fin", busy, 1);
      check("s0_ss_low", SS_n, 0);
      wait_done(400);
      tick(2);

      // Invalid modes never start a burst.
      start_burst(2'b00, 16'h1234, 16'd4, 1'b0, 1'b0, 4'd0);
      check("mode00_busy", busy, 0);
      start_burst(2'b11, 16'h1234, 16'd4, 1'b0, 1'b0, 4'd0);
      check("mode11_busy", busy, 0);
      tick(20);
      check("mode_bad_busy_later", busy, 0);
      check("mode_bad_tx_idle", tx, 1);
      check("mode_bad_ss_idle", SS_n, 1);

      // SPI 8-bit, fall-driven: MOSI at rises = 0x66.
      exp_spi(16'h0066, 8, 1'b0, 288, 0);
      exp_burst(5'd1, 288);
      start_burst(2'b10, 16'h6600, 16'd0, 1'b1, 1'b0, 4'd0);
      check("s1_sclk_setup", SCLK, 1);
      wait_done(400);
      tick(2);

      // SPI 16-bit, rise-driven, two frames with a 32-cycle SS_n gap.
      exp_spi(16'hC3A5, 16, 1'b1, 544, 0);
      exp_spi(16'hC3A5, 16, 1'b1, 544, 32);
      exp_burst(5'd2, 1120);
      start_burst(2'b10, 16'hC3A5, 16'd0, 1'b0, 1'b1, 4'd1);
      wait_done(1500);
      tick(2);

      // Reset in the middle of S_SHIFT abandons the frame without done.
      exp_spi(16'hFFFF, 16, 1'b0, 544, 0);
      start_burst(2'b10, 16'hFFFF, 16'd0, 1'b0, 1'b0, 4'd3);
      tick(100);
      check("r_ss_low_before", SS_n, 0);
      rst = 1'b1;
      tick();
      check("r_ss_n", SS_n, 1);
      check("r_sclk", SCLK, 1);
      check("r_mosi", MOSI, 0);
      check("r_busy", busy, 0);
      check("r_done", done, 0);
      check("r_frm_cnt", frm_cnt, 0);
      rst = 1'b0;
      tick(5);
      check("r_no_done_later", done, 0);

      // A clean frame after the reset.
      exp_spi(16'h8001, 16, 1'b0, 544, 0);
      exp_burst(5'd1, 544);
      start_burst(2'b10, 16'h8001, 16'd0, 1'b0, 1'b0, 4'd0);
      wait_done(800);
      tick(5);

      check("uart_q_drained", uart_q.size(), 0);
      check("spi_q_drained", spi_q.size(), 0);
      check("burst_q_drained", burst_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
